// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the F/D/E pipeline control block.
package pipe_ctrl_pkg;

    // Control FSM: normal flow, or E blocked on a data-memory access.
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // Writeback source select as carried by the E stage.
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    // Architectural zero register; never a forwarding source.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Only the ALU result exists in E early enough to be forwarded.
    function automatic logic wb_forwardable(input logic [1:0] wb_sel);
        return wb_sel == WB_ALU;
    endfunction

endpackage

// File: rtl/fwd_detect.sv
// Combinational RAW hazard decode between the D-stage sources and the E-stage destination.
module fwd_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       rs1_used,
    input  logic       rs2_used,
    input  logic [4:0] rd,
    input  logic       reg_wr,
    input  logic [1:0] wb_sel,
    output logic       hit_a,
    output logic       hit_b,
    output logic       fwd_a,
    output logic       fwd_b,
    output logic       use_stall
);

    logic wr_valid;
    logic alu_src;

    // A match is real only if E writes a register other than x0.
    always_comb begin
        wr_valid  = reg_wr && (rd != REG_ZERO);
        alu_src   = wb_forwardable(wb_sel);
        hit_a     = rs1_used && wr_valid && (rd == rs1);
        hit_b     = rs2_used && wr_valid && (rd == rs2);
        fwd_a     = hit_a && alu_src;
        fwd_b     = hit_b && alu_src;
        use_stall = (hit_a || hit_b) && !alu_src;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard, forwarding and data-memory handshake control for the 3-stage pipeline.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic             rs1_used_D,
    input  logic             rs2_used_D,
    input  logic [4:0]       rd_E,
    input  logic             reg_wr_E,
    input  logic [1:0]       wb_sel_E,
    input  logic             mem_rd_E,
    input  logic             mem_wr_E,
    input  logic             br_taken,
    input  logic             dmem_ack,
    output logic             for_A,
    output logic             for_B,
    output logic             dmem_req,
    output logic             stall_F,
    output logic             stall_D,
    output logic             hold_E,
    output logic             bubble_E,
    output logic             flush_D,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MEM_TIMEOUT);

    state_t            state;
    state_t            state_next;
    logic [WCNT_W-1:0] wait_cnt;
    logic [WCNT_W-1:0] wait_cnt_next;
    logic              timeout_set;
    logic              run_ctrl;
    logic              fwd_en;

    logic hit_a;
    logic hit_b;
    logic fwd_a;
    logic fwd_b;
    logic use_stall;

    fwd_detect u_fwd_detect (
        .rs1       (rs1_D),
        .rs2       (rs2_D),
        .rs1_used  (rs1_used_D),
        .rs2_used  (rs2_used_D),
        .rd        (rd_E),
        .reg_wr    (reg_wr_E),
        .wb_sel    (wb_sel_E),
        .hit_a     (hit_a),
        .hit_b     (hit_b),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b),
        .use_stall (use_stall)
    );

    // Next-state and pipeline control outputs; reset forces a flushed, request-free pipeline.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        timeout_set   = 1'b0;
        run_ctrl      = 1'b0;
        fwd_en        = 1'b0;
        dmem_req      = 1'b0;
        stall_F       = 1'b0;
        stall_D       = 1'b0;
        hold_E        = 1'b0;
        bubble_E      = 1'b0;
        flush_D       = 1'b0;

        if (rst) begin
            bubble_E = 1'b1;
            flush_D  = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    dmem_req = mem_rd_E || mem_wr_E;
                    fwd_en   = 1'b1;
                    if (dmem_req && !dmem_ack) begin
                        stall_F       = 1'b1;
                        stall_D       = 1'b1;
                        hold_E        = 1'b1;
                        state_next    = MEM_WAIT;
                        wait_cnt_next = WCNT_W'(1);
                    end else begin
                        run_ctrl = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    dmem_req = 1'b1;
                    if (dmem_ack || (wait_cnt == WAIT_MAX)) begin
                        // Genuine or forced completion: behave as an unheld RUN cycle.
                        run_ctrl      = 1'b1;
                        fwd_en        = 1'b1;
                        timeout_set   = !dmem_ack;
                        state_next    = RUN;
                        wait_cnt_next = '0;
                    end else begin
                        stall_F       = 1'b1;
                        stall_D       = 1'b1;
                        hold_E        = 1'b1;
                        wait_cnt_next = wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end
            endcase

            // A taken branch squashes D, so a load-use stall on that D is moot.
            if (run_ctrl) begin
                if (br_taken) begin
                    flush_D  = 1'b1;
                    bubble_E = 1'b1;
                end else if (use_stall) begin
                    stall_F  = 1'b1;
                    stall_D  = 1'b1;
                    bubble_E = 1'b1;
                end
            end
        end

        for_A = fwd_en && fwd_a;
        for_B = fwd_en && fwd_b;
    end

    // FSM state, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    // Saturating performance counters for stall and flush cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_F && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (flush_D && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int unsigned CNT_W       = 3;

    logic             clk;
    logic             rst;
    logic [4:0]       rs1_D;
    logic [4:0]       rs2_D;
    logic             rs1_used_D;
    logic             rs2_used_D;
    logic [4:0]       rd_E;
    logic             reg_wr_E;
    logic [1:0]       wb_sel_E;
    logic             mem_rd_E;
    logic             mem_wr_E;
    logic             br_taken;
    logic             dmem_ack;
    logic             for_A;
    logic             for_B;
    logic             dmem_req;
    logic             stall_F;
    logic             stall_D;
    logic             hold_E;
    logic             bubble_E;
    logic             flush_D;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rs1_D       (rs1_D),
        .rs2_D       (rs2_D),
        .rs1_used_D  (rs1_used_D),
        .rs2_used_D  (rs2_used_D),
        .rd_E        (rd_E),
        .reg_wr_E    (reg_wr_E),
        .wb_sel_E    (wb_sel_E),
        .mem_rd_E    (mem_rd_E),
        .mem_wr_E    (mem_wr_E),
        .br_taken    (br_taken),
        .dmem_ack    (dmem_ack),
        .for_A       (for_A),
        .for_B       (for_B),
        .dmem_req    (dmem_req),
        .stall_F     (stall_F),
        .stall_D     (stall_D),
        .hold_E      (hold_E),
        .bubble_E    (bubble_E),
        .flush_D     (flush_D),
        .mem_timeout (mem_timeout),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // All stage inputs quiet: no reads, no writes, no memory op, no branch.
    task automatic idle();
        rs1_D      = 5'd0;
        rs2_D      = 5'd0;
        rs1_used_D = 1'b0;
        rs2_used_D = 1'b0;
        rd_E       = 5'd0;
        reg_wr_E   = 1'b0;
        wb_sel_E   = 2'b00;
        mem_rd_E   = 1'b0;
        mem_wr_E   = 1'b0;
        br_taken   = 1'b0;
        dmem_ack   = 1'b0;
    endtask

    // Advance to just after the next rising edge; inputs change here, checks follow 3 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_stall;
        int n_hold;
        int n_req;

        rst = 1'b1;
        idle();
        mem_rd_E = 1'b1;
        step();
        step();
        #3;
        check("rst_dmem_req", 32'(dmem_req), 0);
        check("rst_bubble_E", 32'(bubble_E), 1);
        check("rst_flush_D", 32'(flush_D), 1);
        check("rst_stall_F", 32'(stall_F), 0);
        check("rst_stall_count", 32'(stall_count), 0);
        check("rst_flush_count", 32'(flush_count), 0);
        check("rst_mem_timeout", 32'(mem_timeout), 0);

        // Out of reset, idle pipe.
        step();
        rst = 1'b0;
        idle();
        #3;
        check("idle_flush_D", 32'(flush_D), 0);
        check("idle_bubble_E", 32'(bubble_E), 0);

        // ALU forward to operand A.
        step();
        rd_E = 5'd5; reg_wr_E = 1'b1; wb_sel_E = 2'b00; rs1_D = 5'd5; rs1_used_D = 1'b1;
        #3;
        check("alu_fwd_for_A", 32'(for_A), 1);
        check("alu_fwd_for_B", 32'(for_B), 0);
        check("alu_fwd_stall_F", 32'(stall_F), 0);

        // x0 is never forwarded.
        step();
        rd_E = 5'd0; rs1_D = 5'd0;
        #3;
        check("x0_for_A", 32'(for_A), 0);
        check("x0_stall_F", 32'(stall_F), 0);

        // ALU forward to operand B only.
        step();
        idle();
        rd_E = 5'd9; reg_wr_E = 1'b1; rs2_D = 5'd9; rs2_used_D = 1'b1; rs1_D = 5'd3;
        rs1_used_D = 1'b1;
        #3;
        check("fwd_b_for_B", 32'(for_B), 1);
        check("fwd_b_for_A", 32'(for_A), 0);

        // Load-use with zero-wait memory: one stall+bubble cycle, no hold.
        step();
        idle();
        mem_rd_E = 1'b1; dmem_ack = 1'b1; wb_sel_E = 2'b01; reg_wr_E = 1'b1; rd_E = 5'd7;
        rs2_D = 5'd7; rs2_used_D = 1'b1;
        #3;
        check("lu_stall_F", 32'(stall_F), 1);
        check("lu_stall_D", 32'(stall_D), 1);
        check("lu_bubble_E", 32'(bubble_E), 1);
        check("lu_hold_E", 32'(hold_E), 0);
        check("lu_dmem_req", 32'(dmem_req), 1);
        check("lu_for_B", 32'(for_B), 0);
        step();
        idle();
        #3;
        check("lu_after_stall_F", 32'(stall_F), 0);
        check("lu_stall_count", 32'(stall_count), 1);

        // Store with three ack-less cycles, ack on the fourth.
        n_stall = 0; n_hold = 0; n_req = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            idle();
            mem_wr_E = 1'b1;
            dmem_ack = (i == 3);
            #3;
            n_stall += int'(stall_F);
            n_hold  += int'(hold_E);
            n_req   += int'(dmem_req);
        end
        check("ws_release_stall_F", 32'(stall_F), 0);
        check("ws_release_hold_E", 32'(hold_E), 0);
        check("ws_stall_cycles", 32'(n_stall), 3);
        check("ws_hold_cycles", 32'(n_hold), 3);
        check("ws_req_cycles", 32'(n_req), 4);
        step();
        idle();
        #3;
        check("ws_back_to_run_req", 32'(dmem_req), 0);
        check("ws_stall_count", 32'(stall_count), 4);

        // Load with ack stuck low: forced release in the 4th MEM_WAIT cycle.
        n_hold = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            idle();
            mem_rd_E = 1'b1;
            wb_sel_E = 2'b01;
            #3;
            n_hold += int'(hold_E);
            check("to_req", 32'(dmem_req), 1);
        end
        check("to_release_hold_E", 32'(hold_E), 0);
        check("to_flag_not_yet", 32'(mem_timeout), 0);
        check("to_hold_cycles", 32'(n_hold), 4);
        step();
        idle();
        dmem_ack = 1'b1;
        #3;
        check("to_mem_timeout", 32'(mem_timeout), 1);
        check("stray_ack_req", 32'(dmem_req), 0);
        check("stray_ack_stall_F", 32'(stall_F), 0);
        check("stall_count_sat", 32'(stall_count), 7);

        // Taken branch together with a load-use match: flush wins.
        step();
        idle();
        br_taken = 1'b1; mem_rd_E = 1'b1; dmem_ack = 1'b1; wb_sel_E = 2'b01; reg_wr_E = 1'b1;
        rd_E = 5'd7; rs1_D = 5'd7; rs1_used_D = 1'b1;
        #3;
        check("br_flush_D", 32'(flush_D), 1);
        check("br_bubble_E", 32'(bubble_E), 1);
        check("br_stall_F", 32'(stall_F), 0);
        step();
        idle();
        #3;
        check("br_flush_count", 32'(flush_count), 1);
        check("br_stall_count_held", 32'(stall_count), 7);
        check("br_mem_timeout_sticky", 32'(mem_timeout), 1);

        // Reset asserted in the 2nd MEM_WAIT cycle of a stalled store.
        step();
        idle();
        mem_wr_E = 1'b1;
        #3;
        check("rmw_enter_hold", 32'(hold_E), 1);
        step();
        #3;
        check("rmw_wait1_hold", 32'(hold_E), 1);
        step();
        rst = 1'b1;
        #3;
        check("rmw_rst_req", 32'(dmem_req), 0);
        check("rmw_rst_hold", 32'(hold_E), 0);
        step();
        rst = 1'b0;
        idle();
        #3;
        check("rmw_run_req", 32'(dmem_req), 0);
        check("rmw_stall_count", 32'(stall_count), 0);
        check("rmw_flush_count", 32'(flush_count), 0);
        check("rmw_mem_timeout", 32'(mem_timeout), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
